// File: rtl/ahb_apb_pkg.sv
// Shared constants and types for the AHB-to-APB bridge.
// Transfer/response encodings, default address map, error FSM states.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam int          DEF_SLOT_BITS = 26;
    localparam int          DEF_NUM_SLOTS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: address/data pipeline,
// transfer qualification, slot decode and two-cycle ERROR response.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          SLOT_BITS = DEF_SLOT_BITS,
    parameter int          NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    input  logic                 Hwrite,
    input  logic                 Hreadyin,
    input  logic [1:0]           Htrans,
    input  logic [31:0]          Haddr,
    input  logic [31:0]          Hwdata,
    input  logic [31:0]          Prdata,
    output logic [31:0]          Hrdata,
    output logic                 valid,
    output logic [31:0]          Haddr1,
    output logic [31:0]          Haddr2,
    output logic [31:0]          Hwdata1,
    output logic [31:0]          Hwdata2,
    output logic                 Hwritereg,
    output logic                 Hwritereg1,
    output logic [NUM_SLOTS-1:0] tempselx,
    output logic [1:0]           Hresp,
    output logic                 Hready_err,
    output logic [3:0]           err_cnt
);

    localparam logic [32:0] WIN = 33'(NUM_SLOTS) << SLOT_BITS;

    // 33-bit offset: addresses below the base wrap to a huge value.
    function automatic logic [NUM_SLOTS-1:0] slot_dec(input logic [32:0] off);
        logic [NUM_SLOTS-1:0] dec;
        dec = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            dec[k] = (off < WIN) && ((off[31:0] >> SLOT_BITS) == 32'(k));
        end
        return dec;
    endfunction

    err_state_e  r_state;
    logic [32:0] w_off;
    logic        w_in_win;
    logic        w_active;

    assign w_off    = {1'b0, Haddr} - {1'b0, BASE_ADDR};
    assign w_in_win = (w_off < WIN);
    assign w_active = Hreadyin && Htrans[1];
    assign valid    = w_active && w_in_win && (r_state == ST_IDLE);
    assign tempselx = slot_dec(w_off);
    assign Hrdata   = Prdata;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Haddr1     <= '0;
            Haddr2     <= '0;
            Hwdata1    <= '0;
            Hwdata2    <= '0;
            Hwritereg  <= 1'b0;
            Hwritereg1 <= 1'b0;
            r_state    <= ST_IDLE;
            Hresp      <= HRESP_OKAY;
            Hready_err <= 1'b1;
            err_cnt    <= '0;
        end else begin
            Haddr1     <= Haddr;
            Haddr2     <= Haddr1;
            Hwdata1    <= Hwdata;
            Hwdata2    <= Hwdata1;
            Hwritereg  <= Hwrite;
            Hwritereg1 <= Hwritereg;
            case (r_state)
                ST_IDLE: begin
                    if (w_active && !w_in_win) begin
                        r_state    <= ST_ERR1;
                        Hresp      <= HRESP_ERROR;
                        Hready_err <= 1'b0;
                        if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state    <= ST_ERR2;
                    Hresp      <= HRESP_ERROR;
                    Hready_err <= 1'b1;
                end
                ST_ERR2: begin
                    r_state    <= ST_IDLE;
                    Hresp      <= HRESP_OKAY;
                    Hready_err <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    Hresp      <= HRESP_OKAY;
                    Hready_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: decode table plus pipeline,
// error-response, reset and saturation sequences.
module tb_ahb_slave_if;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic [31:0] Hrdata;
    logic        valid;
    logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
    logic        Hwritereg, Hwritereg1;
    logic [2:0]  tempselx;
    logic [1:0]  Hresp;
    logic        Hready_err;
    logic [3:0]  err_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 Hclk = ~Hclk;

    ahb_slave_if dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite),
        .Hreadyin(Hreadyin), .Htrans(Htrans), .Haddr(Haddr),
        .Hwdata(Hwdata), .Prdata(Prdata), .Hrdata(Hrdata),
        .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
        .Hwritereg(Hwritereg), .Hwritereg1(Hwritereg1),
        .tempselx(tempselx), .Hresp(Hresp),
        .Hready_err(Hready_err), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [1:0] tr, input logic rdy,
                         input logic [31:0] a, input logic wr);
        Htrans = tr;
        Hreadyin = rdy;
        Haddr = a;
        Hwrite = wr;
    endtask

    task automatic after_edge();
        @(posedge Hclk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  tr;
        logic        rdy;
        logic [31:0] addr;
        logic [31:0] prd;
        logic        ev;
        logic [2:0]  esel;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{2'b10, 1'b1, 32'h8000_0000, 32'h0000_CAFE, 1'b1, 3'b001};
        tbl[1] = '{2'b11, 1'b1, 32'h8400_0000, 32'h0000_0000, 1'b1, 3'b010};
        tbl[2] = '{2'b10, 1'b1, 32'h8BFF_FFFC, 32'h0000_0000, 1'b1, 3'b100};
        tbl[3] = '{2'b00, 1'b1, 32'h8C00_0000, 32'h0000_0000, 1'b0, 3'b000};
        tbl[4] = '{2'b01, 1'b1, 32'h8000_0010, 32'h0000_0000, 1'b0, 3'b001};
        tbl[5] = '{2'b00, 1'b1, 32'h8000_0010, 32'h0000_0000, 1'b0, 3'b001};
        tbl[6] = '{2'b10, 1'b0, 32'h8000_0010, 32'h1234_5678, 1'b0, 3'b001};
        tbl[7] = '{2'b00, 1'b1, 32'h7FFF_FFFC, 32'h0000_0000, 1'b0, 3'b000};

        Hresetn = 1'b0;
        drive(2'b00, 1'b1, 32'h0, 1'b0);
        Hwdata = '0;
        Prdata = '0;
        #12;
        chk("rst_hresp", 32'(Hresp), 32'h0);
        chk("rst_hready_err", 32'(Hready_err), 32'h1);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_haddr1", Haddr1, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        @(negedge Hclk);
        Hresetn = 1'b1;

        // single write
        @(negedge Hclk);
        drive(2'b10, 1'b1, 32'h8000_0001, 1'b1);
        #1;
        chk("sw_valid", 32'(valid), 32'h1);
        chk("sw_sel", 32'(tempselx), 32'h1);
        after_edge();
        chk("sw_haddr1", Haddr1, 32'h8000_0001);
        chk("sw_hwritereg", 32'(Hwritereg), 32'h1);
        @(negedge Hclk);
        drive(2'b00, 1'b1, 32'h0, 1'b0);
        Hwdata = 32'h1234;
        after_edge();
        chk("sw_hwdata1", Hwdata1, 32'h1234);
        chk("sw_haddr2", Haddr2, 32'h8000_0001);
        chk("sw_hwritereg1", 32'(Hwritereg1), 32'h1);

        // burst: NONSEQ + 3 SEQ, data one cycle behind address
        for (int i = 0; i < 5; i++) begin
            @(negedge Hclk);
            if (i < 4)
                drive(i == 0 ? 2'b10 : 2'b11, 1'b1,
                      32'h8000_0001 + 32'(i), 1'b1);
            else
                drive(2'b00, 1'b1, 32'h0, 1'b0);
            if (i > 0) Hwdata = 32'h1234 + 32'(i - 1);
            #1;
            if (i < 4) chk($sformatf("bu_valid%0d", i), 32'(valid), 32'h1);
            after_edge();
            if (i < 4)
                chk($sformatf("bu_haddr1_%0d", i), Haddr1,
                    32'h8000_0001 + 32'(i));
            if (i > 0)
                chk($sformatf("bu_hwdata1_%0d", i), Hwdata1,
                    32'h1234 + 32'(i - 1));
            chk($sformatf("bu_hresp%0d", i), 32'(Hresp), 32'h0);
        end

        // combinational decode / qualifier table
        for (int i = 0; i < 8; i++) begin
            @(negedge Hclk);
            drive(tbl[i].tr, tbl[i].rdy, tbl[i].addr, 1'b0);
            Prdata = tbl[i].prd;
            #1;
            chk($sformatf("tb_valid%0d", i), 32'(valid), 32'(tbl[i].ev));
            chk($sformatf("tb_sel%0d", i), 32'(tempselx), 32'(tbl[i].esel));
            chk($sformatf("tb_hrdata%0d", i), Hrdata, tbl[i].prd);
        end
        after_edge();
        chk("tb_no_err", 32'(Hresp), 32'h0);
        chk("tb_no_errcnt", 32'(err_cnt), 32'h0);

        // out-of-range NONSEQ
        @(negedge Hclk);
        drive(2'b10, 1'b1, 32'h9000_0000, 1'b0);
        #1;
        chk("oor_valid", 32'(valid), 32'h0);
        chk("oor_sel", 32'(tempselx), 32'h0);
        after_edge();
        chk("oor_e1_hresp", 32'(Hresp), 32'h1);
        chk("oor_e1_rdy", 32'(Hready_err), 32'h0);
        chk("oor_cnt", 32'(err_cnt), 32'h1);
        @(negedge Hclk);
        drive(2'b10, 1'b1, 32'h8000_0010, 1'b0);
        #1;
        chk("oor_e1_valid", 32'(valid), 32'h0);
        after_edge();
        chk("oor_e2_hresp", 32'(Hresp), 32'h1);
        chk("oor_e2_rdy", 32'(Hready_err), 32'h1);
        @(negedge Hclk);
        drive(2'b10, 1'b1, 32'h9000_0000, 1'b0);
        #1;
        chk("oor_e2_valid", 32'(valid), 32'h0);
        after_edge();
        chk("oor_ok_hresp", 32'(Hresp), 32'h0);
        chk("oor_ok_rdy", 32'(Hready_err), 32'h1);
        chk("oor_cnt_hold", 32'(err_cnt), 32'h1);

        // below-base address, active
        @(negedge Hclk);
        drive(2'b10, 1'b1, 32'h7FFF_FFFC, 1'b0);
        after_edge();
        chk("low_hresp", 32'(Hresp), 32'h1);
        @(negedge Hclk);
        drive(2'b00, 1'b1, 32'h0, 1'b0);
        after_edge();
        after_edge();
        chk("low_cnt", 32'(err_cnt), 32'h2);

        // async reset in ERR1
        @(negedge Hclk);
        drive(2'b10, 1'b1, 32'h9000_0000, 1'b1);
        Hwdata = 32'hAAAA;
        after_edge();
        chk("ra_hresp_pre", 32'(Hresp), 32'h1);
        #2;
        Hresetn = 1'b0;
        #1;
        chk("ra_hresp", 32'(Hresp), 32'h0);
        chk("ra_rdy", 32'(Hready_err), 32'h1);
        chk("ra_haddr1", Haddr1, 32'h0);
        chk("ra_haddr2", Haddr2, 32'h0);
        chk("ra_hwdata1", Hwdata1, 32'h0);
        chk("ra_hwritereg", 32'(Hwritereg), 32'h0);
        chk("ra_cnt", 32'(err_cnt), 32'h0);
        @(negedge Hclk);
        drive(2'b00, 1'b1, 32'h0, 1'b0);
        Hwdata = '0;
        Hresetn = 1'b1;

        // sixteen errors: counter saturates
        for (int i = 0; i < 16; i++) begin
            @(negedge Hclk);
            drive(2'b10, 1'b1, 32'hA000_0000, 1'b0);
            after_edge();
            @(negedge Hclk);
            drive(2'b00, 1'b1, 32'h0, 1'b0);
            after_edge();
            after_edge();
            if (i == 14) chk("sat_cnt15", 32'(err_cnt), 32'hF);
        end
        chk("sat_cnt16", 32'(err_cnt), 32'hF);
        chk("sat_hresp", 32'(Hresp), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
